// File: rtl/mux_lut_gate_pkg.sv
// Shared types and truth-table constants for the mux-built two-input LUT unit.
package mux_lut_gate_pkg;

  typedef enum logic {S_FIRST, S_CHAIN} state_t;

  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_RESET = TT_OR;

endpackage

// File: rtl/lut2_mux.sv
// One-bit two-input LUT made of three 2:1 muxes; output is tt[{x,y}].
module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic o
);
  assign o = s ? d1 : d0;
endmodule

module lut2_mux (
  input  logic [3:0] tt,
  input  logic       x,
  input  logic       y,
  output logic       o
);
  logic lo, hi;

  // y picks within each half of the table, x picks the half
  mux2 u_lo  (.d0(tt[0]), .d1(tt[1]), .s(y), .o(lo));
  mux2 u_hi  (.d0(tt[2]), .d1(tt[3]), .s(y), .o(hi));
  mux2 u_top (.d0(lo),    .d1(hi),    .s(x), .o(o));
endmodule

// File: rtl/mux_lut_gate_unit.sv
// Streaming WIDTH-bit programmable two-input logic stage with optional
// per-packet accumulation down to a single result word.
module mux_lut_gate_unit
  import mux_lut_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  input  logic             cfg_acc,
  output logic             cfg_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_last
);

  logic [3:0]       tt_q;
  logic             acc_mode_q;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lut_x, f;
  logic             accept, emit, acc_load;

  assign in_ready = !cfg_we && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign cfg_busy = out_valid || (state == S_CHAIN);

  // Mid-packet the running result replaces operand A
  assign lut_x = (state == S_CHAIN) ? acc_q : in_a;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lut2_mux u_lut (.tt(tt_q), .x(lut_x[i]), .y(in_b[i]), .o(f[i]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tt_q       <= TT_RESET;
      acc_mode_q <= 1'b0;
    end else if (cfg_we && !cfg_busy) begin
      tt_q       <= cfg_tt;
      acc_mode_q <= cfg_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FIRST;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept && acc_mode_q) begin
      case (state)
        S_FIRST: state_nxt = in_last ? S_FIRST : S_CHAIN;
        S_CHAIN: state_nxt = in_last ? S_FIRST : S_CHAIN;
        default: state_nxt = S_FIRST;
      endcase
    end
  end

  always_comb begin
    emit     = 1'b0;
    acc_load = 1'b0;
    if (accept) begin
      if (!acc_mode_q || in_last) emit = 1'b1;
      else                        acc_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else if (acc_load) acc_q <= f;
  end

  // A new result may replace the one handed off on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_y     <= f;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mux_lut_gate_unit.md
# mux_lut_gate_unit

Programmable, pipelined, WIDTH-bit two-input logic unit in which every output bit comes from a 2-input lookup table built only from 2:1 muxes. It generalises the fixed mux-built gates to any of the 16 two-input functions, selected by a runtime truth-table register. It adds a valid/ready stream interface and an accumulate mode that folds a whole packet down to one result word. It sits as a streaming stage between a producer and consumer of operand pairs.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- cfg_we  in  1  configuration write strobe
- cfg_tt  in  4  truth table; result bit = cfg_tt[{a,b}] (index 2·a+b)
- cfg_acc  in  1  0 = pass mode, 1 = accumulate mode
- cfg_busy  out  1  high while a configuration write would be ignored
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_last  in  1  final beat of packet
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_last  out  1  result closes a packet

## Operation
- Reset values: tt_q = 4'b1110 (OR), acc_mode_q = 0, state = S_FIRST, out_valid = 0, out_y = 0, out_last = 0, acc_q = 0.
- LUT per bit i: f(x,y) = tt_q[{x,y}]. Mux tree: level 1 selects on y (tt[0]/tt[1] and tt[2]/tt[3]), level 2 selects on x.
- The unit accepts a beat when in_valid && in_ready.
- in_ready = !cfg_we && (!out_valid || out_ready).
- Pass mode (acc_mode_q=0): each accepted beat loads out_y = f(in_a, in_b) and out_last = in_last, and sets out_valid. State stays S_FIRST.
- Accumulate mode (acc_mode_q=1), FSM:
  - S_FIRST, beat accepted, in_last=0: acc_q ← f(in_a,in_b), go to S_CHAIN, no output.
  - S_FIRST, beat accepted, in_last=1: emit f(in_a,in_b) with out_last=1, stay in S_FIRST.
  - S_CHAIN, beat accepted: r = f(acc_q, in_b); in_a is ignored. With in_last=0, acc_q ← r. With in_last=1, emit r with out_last=1, go to S_FIRST.
- Config: cfg_busy = out_valid || state==S_CHAIN.
  - cfg_we while !cfg_busy loads tt_q and acc_mode_q on that edge.
  - cfg_we while cfg_busy is ignored, with no side effects.
  - cfg_we forces in_ready=0, so a config write and a beat acceptance never coincide.
- Output hold: while out_valid && !out_ready, out_y and out_last stay stable.
- Reset mid-packet: abandons the accumulation, discards any pending output, and restores the reset values, including tt_q = OR.

## Timing
- Latency is 1 cycle from accepted beat to out_valid, in pass mode or for the last beat in accumulate mode.
- Throughput is 1 beat per cycle when out_ready is held high.
- On the same edge, an output handshake and a new acceptance may both occur; the new result replaces the old one with no bubble.
- in_ready is combinational from out_valid, out_ready and cfg_we; there is no combinational path from in_valid to in_ready.
- A new tt_q or acc_mode_q applies to beats accepted from the cycle after the write.

## Structure
- Package mux_lut_gate_pkg holds:
  - typedef enum logic {S_FIRST, S_CHAIN} state_t
  - localparams TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_RESET=TT_OR
- Sub-module lut2_mux: 1-bit, built from three 2:1 mux instances with inputs tt[3:0], x, y and output o. It is instantiated WIDTH times via generate. The x input is muxed between in_a and acc_q according to state.
- Top level holds the config register, the FSM, acc_q and the output register/handshake.

## Test plan
- After reset, with no config, pass mode, a=8'hF0, b=8'h0F, in_last=1 → next cycle out_y=8'hFF, out_last=1.
- Write cfg_tt=TT_XOR, then a=8'hAA, b=8'hFF → out_y=8'h55. Write TT_AND with the same operands → 8'hAA. All 16 tt values on a=8'hCC, b=8'hAA → out_y = bitwise tt lookup.
- Accumulate XOR, packet of beats b=8'h01,8'h02,8'h04 (last), first a=8'h00 → exactly one output 8'h07 with out_last=1 and no intermediate out_valid.
- Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, out_y stable, no beats lost. Release with out_ready=1 and random in_valid for 200 beats → results match the reference model in order.
- cfg_we while in S_CHAIN or while out_valid pending → tt_q unchanged and the packet result uses the old function. cfg_we while idle together with in_valid=1 → beat not accepted that cycle and config applied.
- Assert rst mid accumulate packet → next cycle out_valid=0, state S_FIRST, tt_q=OR. A new single-beat packet a=8'h01, b=8'h02 → 8'h03.
